uart_tx_frame_gen: RTL

- Parametrised UART frame serializer for the SYS_TOP UART path.
- Accepts parallel words via a valid/ready handshake and emits start, data (LSB first), optional parity and 1 or 2 stop bits on a serial line.
- Generalises the fixed 11-bit {start, 8 data, even parity, stop} frame to configurable data width, parity mode, stop count and bit period.
- A one-word holding buffer lets consecutive words (e.g. a 16-bit ALU result sent as two bytes) go out with no idle gap.

---
 rtl/uart_tx_pkg.sv | 36 +++
 rtl/uart_tx_frame_gen_if.sv | 49 ++++
 rtl/uart_tx_baud_cnt.sv | 39 +++
 rtl/uart_tx_frame_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module  : uart_tx_pkg
// Purpose : Shared types and line-level constants for the UART frame
//           serializer. The BREAK state exists only when UART_TX_BREAK_EN
//           is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  // Frame sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    BREAK  = 3'd5
`endif
  } tx_state_e;

  // Parity type selector values on the par_typ input
  localparam logic c_PAR_EVEN = 1'b0;
  localparam logic c_PAR_ODD  = 1'b1;

  // Serial line levels
  localparam logic c_IDLE_LEVEL  = 1'b1;
  localparam logic c_STOP_LEVEL  = 1'b1;
  localparam logic c_START_LEVEL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_gen_if.sv
// ============================================================================
// Module  : uart_tx_frame_gen_if
// Purpose : Word handshake, frame configuration and serial-line bundle of the
//           UART frame serializer. send_break is present only when
//           UART_TX_BREAK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_frame_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);

  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  stop2;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  ready;
  logic                  tx_out;
  logic                  busy;
  logic                  frame_done;
`ifdef UART_TX_BREAK_EN
  logic                  send_break;
`endif

  // Upstream word source / configuration owner
  modport master (
`ifdef UART_TX_BREAK_EN
    output send_break,
`endif
    output prescale, par_en, par_typ, stop2, data_in, data_valid,
    input  ready, tx_out, busy, frame_done
  );

  // The serializer itself
  modport slave (
`ifdef UART_TX_BREAK_EN
    input  send_break,
`endif
    input  prescale, par_en, par_typ, stop2, data_in, data_valid,
    output ready, tx_out, busy, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_baud_cnt.sv
// ============================================================================
// Module  : uart_tx_baud_cnt
// Purpose : Bit-period down-counter. i_clear loads max(i_period,1)-1; the
//           counter flags o_bit_end on its zero cycle and reloads itself.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_baud_cnt #(
  parameter int PRESCALE_W = 6
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_clear,
  input  wire logic [PRESCALE_W-1:0] i_period,
  output logic                       o_bit_end
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] w_reload;

  // A period of 0 behaves as 1: reload value 0 gives a bit_end every cycle
  assign w_reload  = (i_period == '0) ? '0 : i_period - PRESCALE_W'(1);
  assign o_bit_end = (r_cnt == '0);

  // Count down, reloading on an explicit clear or on reaching the bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == '0)) begin
      r_cnt <= w_reload;
    end else begin
      r_cnt <= r_cnt - PRESCALE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame_gen.sv
// ============================================================================
// Module  : uart_tx_frame_gen
// Purpose : Parametrised UART frame serializer: start, DATA_WIDTH data bits
//           LSB first, optional parity, 1 or 2 stop bits. A one-word holding
//           buffer allows back-to-back frames with no idle bit.
//           Optional feature macro: UART_TX_BREAK_EN (adds send_break and a
//           BREAK state that holds the line low for a break interval).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame_gen
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  uart_tx_frame_gen_if.slave bus
);

  localparam int c_BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_e r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0]  r_shift;
  logic [DATA_WIDTH-1:0]  r_buf;
  logic                   r_buf_full;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_par_en;
  logic                   r_par_bit;
  logic                   r_stop2;
  logic                   r_stop_cnt;
  logic [PRESCALE_W-1:0]  r_prescale;
  logic [c_BIT_CNT_W-1:0] r_bit_cnt;

  logic                   w_bit_end;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_in_idle;
  logic                   w_last_stop;
  logic                   w_take_in;
  logic                   w_take_buf;
  logic                   w_launch;
  logic                   w_fill_buf;
  logic                   w_cfg_load;
  logic                   w_shift_en;
  logic                   w_tx_nxt;
  logic                   w_par_bit;
  logic [DATA_WIDTH-1:0]  w_launch_data;
  logic [PRESCALE_W-1:0]  w_period;

`ifdef UART_TX_BREAK_EN
  localparam int c_BRK_CNT_W = $clog2(DATA_WIDTH + 4);

  logic [c_BRK_CNT_W-1:0] r_brk_cnt;
  logic [c_BRK_CNT_W-1:0] w_brk_low;
  logic [c_BRK_CNT_W-1:0] w_brk_last_low;
  logic                   w_brk_start;

  // Break holds the line low for DATA_WIDTH+par_en+2 bit periods
  assign w_brk_low      = c_BRK_CNT_W'(DATA_WIDTH + 2) + {{(c_BRK_CNT_W-1){1'b0}}, r_par_en};
  assign w_brk_last_low = w_brk_low - c_BRK_CNT_W'(1);
  // A word accepted in the same idle cycle wins over a break request
  assign w_brk_start    = w_in_idle && bus.send_break && !w_accept;
  assign w_ready        = !r_buf_full && (r_state != BREAK);
  assign w_cfg_load     = w_launch || w_brk_start;
`else
  assign w_ready        = !r_buf_full;
  assign w_cfg_load     = w_launch;
`endif

  assign w_in_idle   = (r_state == IDLE);
  assign w_accept    = bus.data_valid && w_ready;
  assign w_last_stop = (r_state == STOP) && w_bit_end && (!r_stop2 || r_stop_cnt);

  // A word arriving in IDLE or on the final stop cycle launches straight away;
  // otherwise it parks in the holding buffer until the current frame ends.
  assign w_take_in     = w_accept && (w_in_idle || w_last_stop);
  assign w_take_buf    = w_last_stop && r_buf_full;
  assign w_launch      = w_take_in || w_take_buf;
  assign w_fill_buf    = w_accept && !w_take_in;
  assign w_launch_data = w_take_buf ? r_buf : bus.data_in;
  assign w_par_bit     = (bus.par_typ == c_PAR_EVEN) ? ^w_launch_data : ~^w_launch_data;

  // Fresh prescale on the loading edge, latched copy for every later reload
  assign w_period = w_cfg_load ? bus.prescale : r_prescale;

  uart_tx_baud_cnt #(
    .PRESCALE_W (PRESCALE_W)
  ) u_baud_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_cfg_load),
    .i_period  (w_period),
    .o_bit_end (w_bit_end)
  );

  assign bus.ready      = w_ready;
  assign bus.tx_out     = r_tx;
  assign bus.busy       = r_busy;
  assign bus.frame_done = w_last_stop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next serial-line level, decided on bit boundaries
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_shift_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_state_nxt = START;
          w_tx_nxt    = c_START_LEVEL;
        end
`ifdef UART_TX_BREAK_EN
        else if (w_brk_start) begin
          w_state_nxt = BREAK;
          w_tx_nxt    = c_START_LEVEL;
        end
`endif
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
          w_shift_en  = 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_BIT_CNT_W'(DATA_WIDTH)) begin
            w_state_nxt = r_par_en ? PARITY : STOP;
            w_tx_nxt    = r_par_en ? r_par_bit : c_STOP_LEVEL;
          end else begin
            w_tx_nxt    = r_shift[0];
            w_shift_en  = 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_tx_nxt    = c_STOP_LEVEL;
        end
      end
      STOP: begin
        if (w_last_stop) begin
          w_state_nxt = w_launch ? START : IDLE;
          w_tx_nxt    = w_launch ? c_START_LEVEL : c_IDLE_LEVEL;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (w_bit_end) begin
          if (r_brk_cnt == w_brk_low) begin
            w_state_nxt = IDLE;
            w_tx_nxt    = c_IDLE_LEVEL;
          end else if (r_brk_cnt == w_brk_last_low) begin
            w_tx_nxt    = c_STOP_LEVEL;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = c_IDLE_LEVEL;
      end
    endcase
  end

  // Frame datapath: line register, config latch, shifter, holding buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx       <= c_IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= (w_state_nxt != IDLE);

      if (w_cfg_load) begin
        r_prescale <= bus.prescale;
        r_par_en   <= bus.par_en;
      end

      if (w_launch) begin
        r_stop2   <= bus.stop2;
        r_par_bit <= w_par_bit;
        r_shift   <= w_launch_data;
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + c_BIT_CNT_W'(1);
      end

      // Stop-bit counter is meaningful only while in STOP
      if (r_state != STOP) begin
        r_stop_cnt <= 1'b0;
      end else if (w_bit_end) begin
        r_stop_cnt <= 1'b1;
      end

      if (w_take_buf) begin
        r_buf_full <= 1'b0;
      end else if (w_fill_buf) begin
        r_buf      <= bus.data_in;
        r_buf_full <= 1'b1;
      end
    end
  end

`ifdef UART_TX_BREAK_EN
  // Count completed bit periods of a break
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brk_cnt <= '0;
    end else if (w_brk_start) begin
      r_brk_cnt <= '0;
    end else if ((r_state == BREAK) && w_bit_end) begin
      r_brk_cnt <= r_brk_cnt + c_BRK_CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire
